// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer: takes one load/store at a time from the EX/MEM
// boundary and runs it over an SRAM-like port (req / addr_ok / data_ok).
// Store data is lane-replicated with byte strobes; load data is extracted and
// sign/zero-extended. Misaligned accesses complete as address errors without
// touching the port. A flush abandons the access and, if the port has already
// accepted the request, silently absorbs the pending response.
module mem_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic              op_wr,
  input  logic [1:0]        op_size,
  input  logic              op_signed,
  input  logic [ADDR_W-1:0] op_addr,
  input  logic [DATA_W-1:0] op_wdata,
  input  logic              flush,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_rdata,
  output logic              res_adel,
  output logic              res_ades,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  output logic [3:0]        data_wstrb,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_ERR   = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_t              state_q, state_d;
  logic                wr_q;
  logic [1:0]          size_q;
  logic                sgn_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                res_valid_q, res_valid_d;
  logic [DATA_W-1:0]   res_rdata_q, res_rdata_d;
  logic                res_adel_q, res_adel_d;
  logic                res_ades_q, res_ades_d;
  logic                accept;
  logic [1:0]          size_norm;

  // Size 3 is an alias for word; folding it here keeps the rest of the logic 3-valued.
  function automatic logic [1:0] norm_size(input logic [1:0] sz);
    return (sz == 2'd3) ? SZ_WORD : sz;
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      SZ_HALF: return off[0];
      SZ_WORD: return (off != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] store_lanes(input logic [1:0] sz,
                                                    input logic [DATA_W-1:0] wd);
    case (sz)
      SZ_BYTE: return {4{wd[7:0]}};
      SZ_HALF: return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] load_ext(input logic [1:0] sz, input logic sgn,
                                                 input logic [1:0] off,
                                                 input logic [DATA_W-1:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = off[1] ? rd[31:16] : rd[15:0];
    case (sz)
      SZ_BYTE: return sgn ? {{24{b[7]}}, b} : {24'd0, b};
      SZ_HALF: return sgn ? {{16{h[15]}}, h} : {16'd0, h};
      default: return rd;
    endcase
  endfunction

  assign accept    = op_valid & (state_q == S_IDLE) & ~flush;
  assign size_norm = norm_size(op_size);

  // State register and registered result (result is a one-cycle pulse).
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      res_valid_q <= 1'b0;
      res_rdata_q <= '0;
      res_adel_q  <= 1'b0;
      res_ades_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      res_valid_q <= res_valid_d;
      res_rdata_q <= res_rdata_d;
      res_adel_q  <= res_adel_d;
      res_ades_q  <= res_ades_d;
    end
  end

  // Capture the accepted operation; it stays stable for the whole transaction.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      sgn_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      wr_q    <= op_wr;
      size_q  <= size_norm;
      sgn_q   <= op_signed;
      addr_q  <= op_addr;
      wdata_q <= op_wdata;
    end
  end

  // Next-state and result staging; a flush always wins over a completion.
  always_comb begin
    state_d     = state_q;
    res_valid_d = 1'b0;
    res_rdata_d = '0;
    res_adel_d  = 1'b0;
    res_ades_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = misaligned(size_norm, op_addr[1:0]) ? S_ERR : S_REQ;
        end
      end
      S_REQ: begin
        if (flush) begin
          state_d = data_addr_ok ? S_DRAIN : S_IDLE;
        end else if (data_addr_ok) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_d = data_data_ok ? S_IDLE : S_DRAIN;
        end else if (data_data_ok) begin
          state_d     = S_IDLE;
          res_valid_d = 1'b1;
          res_rdata_d = wr_q ? '0 : load_ext(size_q, sgn_q, addr_q[1:0], data_rdata);
        end
      end
      S_DRAIN: begin
        if (data_data_ok) begin
          state_d = S_IDLE;
        end
      end
      S_ERR: begin
        state_d = S_IDLE;
        if (!flush) begin
          res_valid_d = 1'b1;
          res_adel_d  = ~wr_q;
          res_ades_d  = wr_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Port drive: everything is quiet outside REQ so stale captures never leak.
  always_comb begin
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_size  = 2'd0;
    data_addr  = '0;
    data_wdata = '0;
    data_wstrb = 4'b0000;
    if (state_q == S_REQ) begin
      data_req   = 1'b1;
      data_wr    = wr_q;
      data_size  = size_q;
      data_addr  = addr_q;
      data_wdata = wr_q ? store_lanes(size_q, wdata_q) : '0;
      data_wstrb = wr_q ? store_strb(size_q, addr_q[1:0]) : 4'b0000;
    end
  end

  assign op_ready  = (state_q == S_IDLE);
  assign res_valid = res_valid_q;
  assign res_rdata = res_rdata_q;
  assign res_adel  = res_adel_q;
  assign res_ades  = res_ades_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: hand-computed vectors, checked with
// immediate assertions shortly after each rising edge.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        op_valid;
  logic        op_ready;
  logic        op_wr;
  logic [1:0]  op_size;
  logic        op_signed;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic        flush;
  logic        res_valid;
  logic [31:0] res_rdata;
  logic        res_adel;
  logic        res_ades;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .op_valid(op_valid), .op_ready(op_ready), .op_wr(op_wr), .op_size(op_size),
    .op_signed(op_signed), .op_addr(op_addr), .op_wdata(op_wdata), .flush(flush),
    .res_valid(res_valid), .res_rdata(res_rdata), .res_adel(res_adel), .res_ades(res_ades),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic wr, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] a, input logic [31:0] wd);
    op_valid  = 1'b1;
    op_wr     = wr;
    op_size   = sz;
    op_signed = sgn;
    op_addr   = a;
    op_wdata  = wd;
  endtask

  // Zero-wait-state load: accept, addr_ok on the first REQ cycle, data_ok next.
  task automatic zw_load(input string tag, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] a, input logic [31:0] rd,
                         input logic [31:0] exp);
    present(1'b0, sz, sgn, a, 32'h0);
    tick();                                   // accept edge T
    op_valid = 1'b0;
    chk({tag, "_req"}, {31'd0, data_req}, 32'd1);
    chk({tag, "_addr"}, data_addr, a);
    chk({tag, "_wstrb"}, {28'd0, data_wstrb}, 32'd0);
    data_addr_ok = 1'b1;
    tick();                                   // T+1: addr_ok taken
    data_addr_ok = 1'b0;
    chk({tag, "_req_drop"}, {31'd0, data_req}, 32'd0);
    chk({tag, "_no_early_res"}, {31'd0, res_valid}, 32'd0);
    data_data_ok = 1'b1;
    data_rdata   = rd;
    tick();                                   // T+2: data_ok taken, result visible for T+3
    data_data_ok = 1'b0;
    chk({tag, "_res_valid"}, {31'd0, res_valid}, 32'd1);
    chk({tag, "_rdata"}, res_rdata, exp);
    chk({tag, "_ready"}, {31'd0, op_ready}, 32'd1);
    tick();
    chk({tag, "_pulse_end"}, {31'd0, res_valid}, 32'd0);
  endtask

  initial begin
    resetn = 1'b0; op_valid = 1'b0; op_wr = 1'b0; op_size = 2'd0; op_signed = 1'b0;
    op_addr = 32'h0; op_wdata = 32'h0; flush = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;

    // Reset state
    tick(); tick();
    chk("rst_ready", {31'd0, op_ready}, 32'd1);
    chk("rst_req", {31'd0, data_req}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_rdata", res_rdata, 32'h0);
    chk("rst_addr", data_addr, 32'h0);
    chk("rst_wstrb", {28'd0, data_wstrb}, 32'd0);
    resetn = 1'b1;
    tick();

    // 1: signed byte load from lane 3
    zw_load("lb", 2'd0, 1'b1, 32'h0000_1003, 32'h80AB_CD12, 32'hFFFF_FF80);
    // 2: half loads from upper lane, zero- and sign-extended
    zw_load("lhu", 2'd1, 1'b0, 32'h0000_2002, 32'h9ABC_1234, 32'h0000_9ABC);
    zw_load("lh", 2'd1, 1'b1, 32'h0000_2002, 32'h9ABC_1234, 32'hFFFF_9ABC);
    // word load, size 3 alias
    zw_load("lw3", 2'd3, 1'b1, 32'h0000_2004, 32'hCAFE_F00D, 32'hCAFE_F00D);

    // 3: byte store with addr_ok held off for two cycles
    present(1'b1, 2'd0, 1'b0, 32'h0000_3001, 32'h0000_005A);
    tick();
    op_valid = 1'b0;
    chk("sb_wdata", data_wdata, 32'h5A5A_5A5A);
    chk("sb_wstrb", {28'd0, data_wstrb}, 32'h2);
    chk("sb_wr", {31'd0, data_wr}, 32'd1);
    chk("sb_size", {30'd0, data_size}, 32'd0);
    chk("sb_req1", {31'd0, data_req}, 32'd1);
    tick();
    chk("sb_req2", {31'd0, data_req}, 32'd1);
    tick();
    chk("sb_req3", {31'd0, data_req}, 32'd1);
    chk("sb_ready_busy", {31'd0, op_ready}, 32'd0);
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    chk("sb_req_drop", {31'd0, data_req}, 32'd0);
    data_data_ok = 1'b1;
    data_rdata   = 32'hFFFF_FFFF;
    tick();
    data_data_ok = 1'b0;
    chk("sb_res_valid", {31'd0, res_valid}, 32'd1);
    chk("sb_rdata", res_rdata, 32'h0);
    chk("sb_errs", {30'd0, res_adel, res_ades}, 32'd0);
    tick();

    // Half store to upper lane
    present(1'b1, 2'd1, 1'b0, 32'h0000_7002, 32'h1234_BEEF);
    tick();
    op_valid = 1'b0;
    chk("sh_wdata", data_wdata, 32'hBEEF_BEEF);
    chk("sh_wstrb", {28'd0, data_wstrb}, 32'hC);
    chk("sh_size", {30'd0, data_size}, 32'd1);
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    tick();
    data_data_ok = 1'b0;
    chk("sh_res_valid", {31'd0, res_valid}, 32'd1);
    tick();

    // 4: misaligned word load -> address error, no port request
    present(1'b0, 2'd2, 1'b0, 32'h0000_4002, 32'h0);
    tick();
    op_valid = 1'b0;
    chk("lw_mis_req", {31'd0, data_req}, 32'd0);
    chk("lw_mis_busy", {31'd0, op_ready}, 32'd0);
    chk("lw_mis_nores", {31'd0, res_valid}, 32'd0);
    tick();
    chk("lw_mis_req2", {31'd0, data_req}, 32'd0);
    chk("lw_mis_valid", {31'd0, res_valid}, 32'd1);
    chk("lw_mis_adel_ades", {30'd0, res_adel, res_ades}, 32'b10);
    chk("lw_mis_rdata", res_rdata, 32'h0);
    tick();
    chk("lw_mis_pulse_end", {31'd0, res_valid}, 32'd0);

    // Misaligned half store -> store address error
    present(1'b1, 2'd1, 1'b0, 32'h0000_4001, 32'h0000_1111);
    tick();
    op_valid = 1'b0;
    chk("sh_mis_req", {31'd0, data_req}, 32'd0);
    tick();
    chk("sh_mis_valid", {31'd0, res_valid}, 32'd1);
    chk("sh_mis_adel_ades", {30'd0, res_adel, res_ades}, 32'b01);
    tick();

    // 5: flush in WAIT, response arrives two cycles later and is drained
    present(1'b0, 2'd2, 1'b0, 32'h0000_5000, 32'h0);
    tick();
    op_valid = 1'b0;
    data_addr_ok = 1'b1;
    tick();                                   // now WAIT
    data_addr_ok = 1'b0;
    flush = 1'b1;
    tick();                                   // now DRAIN
    flush = 1'b0;
    chk("fl_drain_busy", {31'd0, op_ready}, 32'd0);
    chk("fl_drain_nores", {31'd0, res_valid}, 32'd0);
    tick();
    chk("fl_drain_busy2", {31'd0, op_ready}, 32'd0);
    data_data_ok = 1'b1;
    data_rdata   = 32'h1357_9BDF;
    tick();
    data_data_ok = 1'b0;
    chk("fl_nores", {31'd0, res_valid}, 32'd0);
    chk("fl_ready", {31'd0, op_ready}, 32'd1);
    zw_load("fl_next", 2'd1, 1'b1, 32'h0000_5006, 32'h8001_7FFF, 32'hFFFF_8001);

    // Flush in REQ without addr_ok -> straight back to IDLE, no result
    present(1'b0, 2'd0, 1'b0, 32'h0000_5100, 32'h0);
    tick();
    op_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flreq_ready", {31'd0, op_ready}, 32'd1);
    chk("flreq_req", {31'd0, data_req}, 32'd0);
    chk("flreq_nores", {31'd0, res_valid}, 32'd0);

    // 6: reset in REQ, then a stray data_ok in IDLE
    present(1'b0, 2'd2, 1'b0, 32'h0000_6000, 32'h0);
    tick();
    op_valid = 1'b0;
    chk("rreq_req_before", {31'd0, data_req}, 32'd1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("rreq_req", {31'd0, data_req}, 32'd0);
    chk("rreq_ready", {31'd0, op_ready}, 32'd1);
    chk("rreq_nores", {31'd0, res_valid}, 32'd0);
    data_data_ok = 1'b1;
    data_rdata   = 32'hDEAD_BEEF;
    tick();
    data_data_ok = 1'b0;
    chk("stray_nores", {31'd0, res_valid}, 32'd0);
    chk("stray_ready", {31'd0, op_ready}, 32'd1);
    chk("stray_req", {31'd0, data_req}, 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
